// File: rtl/otter_fetch_queue.sv
// Instruction fetch front end: issues sequential IMEM reads, buffers returned
// words with their PCs in a small FIFO, and flushes on a branch redirect.
module otter_fetch_queue #(
    parameter logic [31:0] RESET_VEC = 32'h0000_0000,
    parameter int          DEPTH     = 4
) (
    input  logic                     CLK,
    input  logic                     RESET,
    output logic [31:0]              IMEM_ADDR,
    output logic                     IMEM_RD,
    input  logic [31:0]              IMEM_DOUT,
    input  logic                     REDIRECT,
    input  logic [31:0]              REDIRECT_PC,
    input  logic                     DE_READY,
    output logic                     DE_VALID,
    output logic [31:0]              DE_PC,
    output logic [31:0]              DE_IR,
    output logic [$clog2(DEPTH):0]   COUNT
);

    localparam int             AW       = $clog2(DEPTH);
    localparam logic [AW:0]    FULL_CNT = (AW + 1)'(DEPTH);

    logic [31:0]   fpc_q, fpc_d;
    logic          inflight_q, inflight_d;
    logic [31:0]   ipc_q, ipc_d;
    logic [AW-1:0] head_q, head_d;
    logic [AW-1:0] tail_q, tail_d;
    logic [AW:0]   count_q, count_d;

    logic [31:0]   pc_mem [DEPTH];
    logic [31:0]   ir_mem [DEPTH];

    logic          issue;
    logic          push;
    logic          pop;
    logic [AW:0]   occ;

    // Decode handshake: an entry transfers on a rising edge where DE_VALID and
    // DE_READY are both high; while DE_VALID is high and DE_READY low the head
    // entry (DE_PC/DE_IR) is held unchanged. REDIRECT masks DE_VALID.
    always_comb begin
        occ      = count_q + {{AW{1'b0}}, inflight_q};
        issue    = RESET && !REDIRECT && (occ < FULL_CNT);
        push     = inflight_q && !REDIRECT;
        pop      = (count_q != '0) && !REDIRECT && DE_READY;

        fpc_d      = fpc_q;
        inflight_d = inflight_q;
        ipc_d      = ipc_q;
        head_d     = head_q;
        tail_d     = tail_q;
        count_d    = count_q;

        if (REDIRECT) begin
            // Flush wins over everything; the word returning next cycle is dropped.
            fpc_d      = {REDIRECT_PC[31:2], 2'b00};
            inflight_d = 1'b0;
            head_d     = '0;
            tail_d     = '0;
            count_d    = '0;
        end else begin
            inflight_d = issue;
            if (issue) begin
                fpc_d = fpc_q + 32'd4;
                ipc_d = fpc_q;
            end
            if (push) tail_d = tail_q + 1'b1;
            if (pop)  head_d = head_q + 1'b1;
            case ({push, pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            fpc_q      <= {RESET_VEC[31:2], 2'b00};
            inflight_q <= 1'b0;
            ipc_q      <= '0;
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
        end else begin
            fpc_q      <= fpc_d;
            inflight_q <= inflight_d;
            ipc_q      <= ipc_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
        end
    end

    // Storage needs no reset: occupancy alone decides what is visible.
    always_ff @(posedge CLK) begin
        if (push) begin
            pc_mem[tail_q] <= ipc_q;
            ir_mem[tail_q] <= IMEM_DOUT;
        end
    end

    assign IMEM_ADDR = fpc_q;
    assign IMEM_RD   = issue;
    assign DE_VALID  = (count_q != '0) && !REDIRECT;
    assign DE_PC     = pc_mem[head_q];
    assign DE_IR     = ir_mem[head_q];
    assign COUNT     = count_q;

endmodule

// File: tb/tb_otter_fetch_queue.sv
// Directed bench for otter_fetch_queue: cycle table plus redirect/reset sequences.
module tb_otter_fetch_queue;

    logic        CLK;
    logic        RESET;
    logic [31:0] IMEM_ADDR;
    logic        IMEM_RD;
    logic [31:0] IMEM_DOUT;
    logic        REDIRECT;
    logic [31:0] REDIRECT_PC;
    logic        DE_READY;
    logic        DE_VALID;
    logic [31:0] DE_PC;
    logic [31:0] DE_IR;
    logic [2:0]  COUNT;

    int checks = 0;
    int errors = 0;

    otter_fetch_queue #(.RESET_VEC(32'h0000_0000), .DEPTH(4)) dut (
        .CLK         (CLK),
        .RESET       (RESET),
        .IMEM_ADDR   (IMEM_ADDR),
        .IMEM_RD     (IMEM_RD),
        .IMEM_DOUT   (IMEM_DOUT),
        .REDIRECT    (REDIRECT),
        .REDIRECT_PC (REDIRECT_PC),
        .DE_READY    (DE_READY),
        .DE_VALID    (DE_VALID),
        .DE_PC       (DE_PC),
        .DE_IR       (DE_IR),
        .COUNT       (COUNT)
    );

    // clock / reset
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // instruction memory model: one-cycle read latency
    initial IMEM_DOUT = 32'h0;
    always @(posedge CLK) if (IMEM_RD) IMEM_DOUT <= 32'hA000_0000 | IMEM_ADDR;

    typedef struct {
        logic        redir;
        logic [31:0] rpc;
        logic        rdy;
        logic        e_rd;
        logic [31:0] e_addr;
        logic        e_val;
        logic [31:0] e_pc;
        logic [2:0]  e_cnt;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(logic redir, logic [31:0] rpc, logic rdy, logic e_rd,
                                logic [31:0] e_addr, logic e_val, logic [31:0] e_pc,
                                logic [2:0] e_cnt);
        vec_t v;
        v = '{redir, rpc, rdy, e_rd, e_addr, e_val, e_pc, e_cnt};
        vecs.push_back(v);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic redir, input logic [31:0] rpc, input logic rdy);
        REDIRECT    = redir;
        REDIRECT_PC = rpc;
        DE_READY    = rdy;
        #1;
    endtask

    task automatic chk_outs(input string tag, input logic e_rd, input logic [31:0] e_addr,
                            input logic e_val, input logic [31:0] e_pc, input logic [2:0] e_cnt);
        chk({tag, ".rd"},    32'(IMEM_RD),  32'(e_rd));
        chk({tag, ".addr"},  IMEM_ADDR,     e_addr);
        chk({tag, ".valid"}, 32'(DE_VALID), 32'(e_val));
        chk({tag, ".count"}, 32'(COUNT),    32'(e_cnt));
        if (e_val) begin
            chk({tag, ".pc"}, DE_PC, e_pc);
            chk({tag, ".ir"}, DE_IR, 32'hA000_0000 | e_pc);
        end
    endtask

    initial begin
        RESET = 1'b0;
        drive(1'b0, 32'h0, 1'b1);

        //   redir rpc            rdy  rd  addr           val pc             cnt
        add(0, 32'h0,          1,   1, 32'h0000_0000, 0, 32'h0,          0);
        add(0, 32'h0,          1,   1, 32'h0000_0004, 0, 32'h0,          0);
        add(0, 32'h0,          1,   1, 32'h0000_0008, 1, 32'h0000_0000, 1);
        add(0, 32'h0,          1,   1, 32'h0000_000C, 1, 32'h0000_0004, 1);
        add(0, 32'h0,          0,   1, 32'h0000_0010, 1, 32'h0000_0008, 1);
        add(0, 32'h0,          0,   1, 32'h0000_0014, 1, 32'h0000_0008, 2);
        add(0, 32'h0,          0,   0, 32'h0000_0018, 1, 32'h0000_0008, 3);
        add(0, 32'h0,          0,   0, 32'h0000_0018, 1, 32'h0000_0008, 4);
        add(0, 32'h0,          1,   0, 32'h0000_0018, 1, 32'h0000_0008, 4);
        add(0, 32'h0,          1,   1, 32'h0000_0018, 1, 32'h0000_000C, 3);
        add(0, 32'h0,          1,   1, 32'h0000_001C, 1, 32'h0000_0010, 2);
        add(1, 32'h0000_0103,  1,   0, 32'h0000_0020, 0, 32'h0,          2);
        add(0, 32'h0,          1,   1, 32'h0000_0100, 0, 32'h0,          0);
        add(0, 32'h0,          1,   1, 32'h0000_0104, 0, 32'h0,          0);
        add(0, 32'h0,          1,   1, 32'h0000_0108, 1, 32'h0000_0100, 1);
        add(1, 32'hFFFF_FFFC,  1,   0, 32'h0000_010C, 0, 32'h0,          1);
        add(0, 32'h0,          1,   1, 32'hFFFF_FFFC, 0, 32'h0,          0);
        add(0, 32'h0,          1,   1, 32'h0000_0000, 0, 32'h0,          0);
        add(0, 32'h0,          1,   1, 32'h0000_0004, 1, 32'hFFFF_FFFC, 1);
        add(0, 32'h0,          1,   1, 32'h0000_0008, 1, 32'h0000_0000, 1);

        // reset state
        repeat (2) @(negedge CLK);
        #1;
        chk_outs("reset", 1'b0, 32'h0, 1'b0, 32'h0, 3'd0);

        // release between edges, then walk the table one cycle per vector
        @(negedge CLK);
        RESET = 1'b1;
        foreach (vecs[i]) begin
            drive(vecs[i].redir, vecs[i].rpc, vecs[i].rdy);
            chk_outs($sformatf("v%0d", i), vecs[i].e_rd, vecs[i].e_addr, vecs[i].e_val,
                     vecs[i].e_pc, vecs[i].e_cnt);
            @(negedge CLK);
        end

        // asynchronous reset mid-operation with two entries queued
        drive(1'b0, 32'h0, 1'b0);
        @(negedge CLK);
        drive(1'b0, 32'h0, 1'b0);
        chk("areset.pre_count", 32'(COUNT), 32'd2);
        chk("areset.pre_pc", DE_PC, 32'h0000_0004);
        #1 RESET = 1'b0;
        #1;
        chk_outs("areset.now", 1'b0, 32'h0, 1'b0, 32'h0, 3'd0);
        @(negedge CLK);
        RESET = 1'b1;
        drive(1'b0, 32'h0, 1'b1);
        chk_outs("areset.c0", 1'b1, 32'h0, 1'b0, 32'h0, 3'd0);
        @(negedge CLK);
        @(negedge CLK);
        drive(1'b0, 32'h0, 1'b1);
        chk_outs("areset.c2", 1'b1, 32'h8, 1'b1, 32'h0, 3'd1);

        // redirect with COUNT=3 and a fetch in flight
        @(negedge CLK);
        RESET = 1'b0;
        @(negedge CLK);
        RESET = 1'b1;
        for (int c = 0; c < 4; c++) begin
            drive(1'b0, 32'h0, 1'b0);
            @(negedge CLK);
        end
        drive(1'b0, 32'h0, 1'b0);
        chk_outs("redir.full", 1'b0, 32'h10, 1'b1, 32'h0, 3'd3);
        drive(1'b1, 32'h0000_0100, 1'b0);
        chk_outs("redir.cyc", 1'b0, 32'h10, 1'b0, 32'h0, 3'd3);
        @(negedge CLK);
        drive(1'b0, 32'h0, 1'b1);
        chk_outs("redir.c1", 1'b1, 32'h100, 1'b0, 32'h0, 3'd0);
        @(negedge CLK);
        drive(1'b0, 32'h0, 1'b1);
        chk_outs("redir.c2", 1'b1, 32'h104, 1'b0, 32'h0, 3'd0);
        @(negedge CLK);
        drive(1'b0, 32'h0, 1'b1);
        chk_outs("redir.c3", 1'b1, 32'h108, 1'b1, 32'h100, 3'd1);
        @(negedge CLK);
        drive(1'b0, 32'h0, 1'b1);
        chk_outs("redir.c4", 1'b1, 32'h10C, 1'b1, 32'h104, 3'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/otter_fetch_queue.md
OTTER_FETCH_QUEUE -- requirements
Module: otter_fetch_queue

Interface
REQ-001 SHALL have parameter RESET_VEC, default 32'h0000_0000, first fetch address after reset.
REQ-002 SHALL have parameter DEPTH, default 4, queue entries; power of two, at least 4.
REQ-003 SHALL have port CLK, input, 1, sole clock; all state updates on its rising edge.
REQ-004 SHALL have port RESET, input, 1; reset is asynchronous and active-low.
REQ-005 SHALL have port IMEM_ADDR, output, 32, instruction-memory read address (fetch PC).
REQ-006 SHALL have port IMEM_RD, output, 1, instruction-memory read enable.
REQ-007 SHALL have port IMEM_DOUT, input, 32, instruction word, valid the cycle after IMEM_RD was high.
REQ-008 SHALL have port REDIRECT, input, 1, taken branch/jump from execute; flush request.
REQ-009 SHALL have port REDIRECT_PC, input, 32, new fetch target, sampled when REDIRECT=1.
REQ-010 SHALL have port DE_READY, input, 1, decode stage accepts the head entry.
REQ-011 SHALL have port DE_VALID, output, 1, head entry valid for decode.
REQ-012 SHALL have port DE_PC, output, 32, PC of head entry.
REQ-013 SHALL have port DE_IR, output, 32, instruction word of head entry.
REQ-014 SHALL have port COUNT, output, log2(DEPTH)+1, current queue occupancy.

Function
REQ-015 SHALL hold fetch PC register fpc; IMEM_ADDR = fpc; fpc[1:0] always 2'b00.
REQ-016 SHALL assert IMEM_RD iff RESET=1, REDIRECT=0, and COUNT + inflight < DEPTH (inflight = 1 if IMEM_RD was high last cycle and not squashed).
REQ-017 SHALL, on an edge with IMEM_RD=1, set fpc <= fpc + 4 (modulo 2^32, 32'hFFFF_FFFC wraps to 0) and record the issued PC with inflight=1.
REQ-018 SHALL, in the cycle after an unsquashed issue, write {issued PC, IMEM_DOUT} into the tail entry at the next edge.
REQ-019 SHALL drive DE_VALID = (COUNT != 0) && !REDIRECT; DE_PC/DE_IR = head entry contents, held stable while DE_VALID=1 and DE_READY=0.
REQ-020 SHALL pop the head on an edge with DE_VALID=1 and DE_READY=1.
REQ-021 SHALL keep COUNT unchanged on simultaneous push and pop; +1 on push only; -1 on pop only.
REQ-022 SHALL never push when full and never pop when empty; the issue rule of REQ-016 guarantees no overflow.
REQ-023 SHALL deliver entries in strict fetch order with no loss or duplication.
REQ-024 SHALL, on an edge with REDIRECT=1: set fpc <= {REDIRECT_PC[31:2],2'b00}, empty the queue (COUNT=0, pointers equal), squash any in-flight fetch so its IMEM_DOUT next cycle is discarded, and perform no pop.
REQ-025 SHALL issue the first fetch at the redirect target in the cycle after REDIRECT, and present it on DE_VALID two cycles after that issue.
REQ-026 Latency: fetch issued in cycle N SHALL appear on DE_VALID/DE_PC/DE_IR in cycle N+2.
REQ-027 Throughput: with DE_READY held 1 and no redirect, SHALL sustain one instruction per cycle after the initial two-cycle fill.
REQ-028 SHALL give REDIRECT priority over push, pop and issue in the same cycle.

Reset
REQ-029 While RESET=0, SHALL asynchronously force fpc=RESET_VEC, COUNT=0, head/tail pointers=0, inflight=0, IMEM_RD=0, DE_VALID=0.
REQ-030 Reset asserted mid-operation SHALL discard all queued and in-flight entries; no entry from before reset SHALL appear afterward.
REQ-031 At the first rising edge with RESET=1, SHALL issue a fetch at RESET_VEC.

Verification
REQ-032 Reset release, RESET_VEC=0, DE_READY=1, IMEM model returns 32'hA000_0000|addr -> IMEM_ADDR 0,4,8,... on consecutive cycles; DE_VALID first high 2 cycles after first issue with DE_PC=0, DE_IR=32'hA000_0000; then one per cycle.
REQ-033 DE_READY=0 from reset -> COUNT reaches 4, IMEM_RD low once COUNT+inflight=4; releasing DE_READY delivers PCs 0,4,8,12,16 in order, no gaps or repeats.
REQ-034 COUNT=3 with a fetch in flight, REDIRECT=1 with REDIRECT_PC=32'h0000_0100 -> DE_VALID=0 that cycle, COUNT=0 next cycle, stale IMEM_DOUT dropped, IMEM_ADDR=32'h100, first delivered DE_PC=32'h100.
REQ-035 REDIRECT_PC=32'h0000_0103 -> fetch issued at 32'h0000_0100.
REQ-036 REDIRECT_PC=32'hFFFF_FFFC, DE_READY=1 -> consecutive fetches at 32'hFFFF_FFFC then 32'h0000_0000.
REQ-037 RESET driven low between clock edges with COUNT=2 -> DE_VALID, IMEM_RD, COUNT go 0 immediately; after release first DE_PC=RESET_VEC.
